// File: rtl/jelly2_jfive_boot_loader_pkg.sv
// Shared types for the jfive boot loader.
// Latency: n/a (types only).
// Backpressure: n/a.
package jelly2_jfive_boot_loader_pkg;

    // Boot sequencer states. IDLE/DONE/ERROR are the passthrough states.
    // READ/WAIT/WRITE/CTL are the busy states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        CTL   = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

endpackage

// File: rtl/jelly2_jfive_boot_wb_mux.sv
// Host/boot WISHBONE select: host passthrough when idle, boot master when busy.
// Latency: purely combinational, zero cycles.
// Backpressure: while busy the host sees no ack, so its strobe stalls until passthrough returns.
// Ports: busy selects the source; s_wb_* is the host side, boot_* is the
//        sequencer's registered master, and m_wb_* goes to the controller.
module jelly2_jfive_boot_wb_mux #(
    parameter int WB_ADR_WIDTH = 24,
    parameter int WB_DAT_WIDTH = 64,
    parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8
) (
    input  logic                    busy,

    input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
    input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
    input  logic                    s_wb_we_i,
    input  logic                    s_wb_stb_i,
    output logic                    s_wb_ack_o,

    input  logic [WB_ADR_WIDTH-1:0] boot_adr,
    input  logic [WB_DAT_WIDTH-1:0] boot_dat,
    input  logic [WB_SEL_WIDTH-1:0] boot_sel,
    input  logic                    boot_we,
    input  logic                    boot_stb,

    output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
    input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
    output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
    output logic                    m_wb_we_o,
    output logic                    m_wb_stb_o,
    input  logic                    m_wb_ack_i
);

    assign m_wb_adr_o = busy ? boot_adr : s_wb_adr_i;
    assign m_wb_dat_o = busy ? boot_dat : s_wb_dat_i;
    assign m_wb_sel_o = busy ? boot_sel : s_wb_sel_i;
    assign m_wb_we_o  = busy ? boot_we  : s_wb_we_i;
    assign m_wb_stb_o = busy ? boot_stb : s_wb_stb_i;

    // The host must never see read data or an ack belonging to a boot write.
    assign s_wb_dat_o = busy ? '0   : m_wb_dat_i;
    assign s_wb_ack_o = busy ? 1'b0 : m_wb_ack_i;

endmodule

// File: rtl/jelly2_jfive_boot_loader.sv
// Boot sequencer: copies a ROM image into jfive TCM, then writes the reset-control register.
// Latency: 3 cycles/word with zero-wait ack, plus 1 CTL cycle and 1 IDLE cycle before the first read.
// Backpressure: each master write holds until ack or TIMEOUT; host strobes are stalled while busy.
// Ports: reset/clk/cke control; start/busy/done/error give boot status;
//        m_rom_* reads the image; s_wb_* is the host port; m_wb_* goes to the controller.
module jelly2_jfive_boot_loader
    import jelly2_jfive_boot_loader_pkg::*;
#(
    parameter int                      WB_ADR_WIDTH  = 24,
    parameter int                      WB_DAT_WIDTH  = 64,
    parameter int                      WB_SEL_WIDTH  = WB_DAT_WIDTH / 8,
    parameter logic [WB_ADR_WIDTH-1:0] TCM_ADR       = 24'h01_0000,
    parameter logic [WB_ADR_WIDTH-1:0] CTL_ADR       = 24'h00_0000,
    parameter logic [WB_DAT_WIDTH-1:0] CTL_DAT       = '0,
    parameter int                      BOOT_WORDS    = 512,
    parameter int                      ROM_ADR_WIDTH = 9,
    parameter bit                      AUTO_START    = 1'b1,
    parameter int                      TIMEOUT       = 256
) (
    input  logic                     reset,
    input  logic                     clk,
    input  logic                     cke,

    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     error,

    output logic                     m_rom_en,
    output logic [ROM_ADR_WIDTH-1:0] m_rom_addr,
    input  logic [WB_DAT_WIDTH-1:0]  m_rom_dout,

    input  logic [WB_ADR_WIDTH-1:0]  s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]  s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]  s_wb_dat_o,
    input  logic [WB_SEL_WIDTH-1:0]  s_wb_sel_i,
    input  logic                     s_wb_we_i,
    input  logic                     s_wb_stb_i,
    output logic                     s_wb_ack_o,

    output logic [WB_ADR_WIDTH-1:0]  m_wb_adr_o,
    input  logic [WB_DAT_WIDTH-1:0]  m_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]  m_wb_dat_o,
    output logic [WB_SEL_WIDTH-1:0]  m_wb_sel_o,
    output logic                     m_wb_we_o,
    output logic                     m_wb_stb_o,
    input  logic                     m_wb_ack_i
);

    localparam int IDX_W = ROM_ADR_WIDTH + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BOOT_WORDS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    state_t                    state;
    logic                      pending;
    logic [IDX_W-1:0]          index;
    logic [TO_W-1:0]           tcnt;
    logic [WB_ADR_WIDTH-1:0]   boot_adr;
    logic [WB_DAT_WIDTH-1:0]   boot_dat;
    logic                      boot_stb;

    assign m_rom_addr = index[ROM_ADR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pending  <= AUTO_START;
            index    <= '0;
            tcnt     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            m_rom_en <= 1'b0;
            boot_adr <= '0;
            boot_dat <= '0;
            boot_stb <= 1'b0;
        end else if (cke) begin
            // The ROM enable is a one-cycle pulse issued on entry to READ.
            m_rom_en <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    // Only launch between host cycles so a host access is never cut.
                    if (pending && !s_wb_stb_i) begin
                        state    <= READ;
                        pending  <= 1'b0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        index    <= '0;
                        m_rom_en <= 1'b1;
                    end else if (start) begin
                        pending  <= 1'b1;
                    end
                end

                READ: begin
                    state <= WAIT;
                end

                WAIT: begin
                    // ROM data is valid now; latch it straight into the master data register.
                    state    <= WRITE;
                    boot_adr <= TCM_ADR + WB_ADR_WIDTH'(index);
                    boot_dat <= m_rom_dout;
                    boot_stb <= 1'b1;
                    tcnt     <= '0;
                end

                WRITE: begin
                    if (m_wb_ack_i) begin
                        if (index == LAST_IDX) begin
                            state    <= CTL;
                            boot_adr <= CTL_ADR;
                            boot_dat <= CTL_DAT;
                            tcnt     <= '0;
                        end else begin
                            state    <= READ;
                            boot_stb <= 1'b0;
                            index    <= index + IDX_W'(1);
                            m_rom_en <= 1'b1;
                        end
                    end else if (tcnt == TO_LAST) begin
                        state    <= ERROR;
                        boot_stb <= 1'b0;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end

                CTL: begin
                    if (m_wb_ack_i) begin
                        state    <= DONE;
                        boot_stb <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else if (tcnt == TO_LAST) begin
                        state    <= ERROR;
                        boot_stb <= 1'b0;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    boot_stb <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    jelly2_jfive_boot_wb_mux #(
        .WB_ADR_WIDTH (WB_ADR_WIDTH),
        .WB_DAT_WIDTH (WB_DAT_WIDTH),
        .WB_SEL_WIDTH (WB_SEL_WIDTH)
    ) u_wb_mux (
        .busy       (busy),
        .s_wb_adr_i (s_wb_adr_i),
        .s_wb_dat_i (s_wb_dat_i),
        .s_wb_dat_o (s_wb_dat_o),
        .s_wb_sel_i (s_wb_sel_i),
        .s_wb_we_i  (s_wb_we_i),
        .s_wb_stb_i (s_wb_stb_i),
        .s_wb_ack_o (s_wb_ack_o),
        .boot_adr   (boot_adr),
        .boot_dat   (boot_dat),
        .boot_sel   ({WB_SEL_WIDTH{1'b1}}),
        .boot_we    (1'b1),
        .boot_stb   (boot_stb),
        .m_wb_adr_o (m_wb_adr_o),
        .m_wb_dat_i (m_wb_dat_i),
        .m_wb_dat_o (m_wb_dat_o),
        .m_wb_sel_o (m_wb_sel_o),
        .m_wb_we_o  (m_wb_we_o),
        .m_wb_stb_o (m_wb_stb_o),
        .m_wb_ack_i (m_wb_ack_i)
    );

endmodule

// File: tb/tb_jelly2_jfive_boot_loader.sv
// Directed bench for the jfive boot loader (BOOT_WORDS=4, TIMEOUT=16).
// Covers auto-boot, host stall, start deferral, timeout, mid-boot reset and clock enable.
// The controller model acks combinationally on strobe when ack_en is set.
module tb_jelly2_jfive_boot_loader;

    localparam int AW = 24;
    localparam int DW = 64;
    localparam int SW = 8;
    localparam logic [DW-1:0] SLAVE_RD = 64'hA5A5_0000_C3C3_0001;

    logic          reset;
    logic          clk = 1'b0;
    logic          cke;
    logic          start;
    logic          busy, done, error;
    logic          m_rom_en;
    logic [8:0]    m_rom_addr;
    logic [DW-1:0] m_rom_dout = '0;
    logic [AW-1:0] s_wb_adr_i;
    logic [DW-1:0] s_wb_dat_i;
    logic [DW-1:0] s_wb_dat_o;
    logic [SW-1:0] s_wb_sel_i;
    logic          s_wb_we_i, s_wb_stb_i, s_wb_ack_o;
    logic [AW-1:0] m_wb_adr_o;
    logic [DW-1:0] m_wb_dat_i;
    logic [DW-1:0] m_wb_dat_o;
    logic [SW-1:0] m_wb_sel_o;
    logic          m_wb_we_o, m_wb_stb_o, m_wb_ack_i;
    logic          ack_en;

    int tests = 0;
    int fails = 0;

    logic [AW-1:0] wr_adr[$];
    logic [DW-1:0] wr_dat[$];

    jelly2_jfive_boot_loader #(
        .BOOT_WORDS (4),
        .TIMEOUT    (16)
    ) dut (
        .reset      (reset),
        .clk        (clk),
        .cke        (cke),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .m_rom_en   (m_rom_en),
        .m_rom_addr (m_rom_addr),
        .m_rom_dout (m_rom_dout),
        .s_wb_adr_i (s_wb_adr_i),
        .s_wb_dat_i (s_wb_dat_i),
        .s_wb_dat_o (s_wb_dat_o),
        .s_wb_sel_i (s_wb_sel_i),
        .s_wb_we_i  (s_wb_we_i),
        .s_wb_stb_i (s_wb_stb_i),
        .s_wb_ack_o (s_wb_ack_o),
        .m_wb_adr_o (m_wb_adr_o),
        .m_wb_dat_i (m_wb_dat_i),
        .m_wb_dat_o (m_wb_dat_o),
        .m_wb_sel_o (m_wb_sel_o),
        .m_wb_we_o  (m_wb_we_o),
        .m_wb_stb_o (m_wb_stb_o),
        .m_wb_ack_i (m_wb_ack_i)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: ROM[i] = 0x1111_0000 + i.
    always @(posedge clk) begin
        if (m_rom_en) m_rom_dout <= 64'h1111_0000 + 64'(m_rom_addr);
    end

    assign m_wb_ack_i = ack_en & m_wb_stb_o;
    assign m_wb_dat_i = SLAVE_RD;

    // Record every boot write the controller accepts.
    always @(posedge clk) begin
        if (!reset && cke && busy && m_wb_stb_o && m_wb_ack_i && m_wb_we_o) begin
            wr_adr.push_back(m_wb_adr_o);
            wr_dat.push_back(m_wb_dat_o);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_writes();
        wr_adr.delete();
        wr_dat.delete();
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 64'(wr_adr.size()), 64'd5);
        if (wr_adr.size() == 5) begin
            for (int i = 0; i < 4; i++) begin
                check({tag, "_adr"}, 64'(wr_adr[i]), 64'h1_0000 + 64'(i));
                check({tag, "_dat"}, wr_dat[i], 64'h1111_0000 + 64'(i));
            end
            check({tag, "_ctl_adr"}, 64'(wr_adr[4]), 64'h0);
            check({tag, "_ctl_dat"}, wr_dat[4], 64'h0);
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (!done && n < limit) begin
            step();
            n++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic stall_bad;
        logic busy_seen;
        logic found;

        reset      = 1'b1;
        cke        = 1'b1;
        start      = 1'b0;
        ack_en     = 1'b1;
        s_wb_adr_i = '0;
        s_wb_dat_i = '0;
        s_wb_sel_i = '0;
        s_wb_we_i  = 1'b0;
        s_wb_stb_i = 1'b0;

        // ---- reset state
        repeat (3) step();
        check("rst_busy",   64'(busy),       64'd0);
        check("rst_done",   64'(done),       64'd0);
        check("rst_error",  64'(error),      64'd0);
        check("rst_rom_en", 64'(m_rom_en),   64'd0);
        check("rst_stb",    64'(m_wb_stb_o), 64'd0);
        check("rst_idx",    64'(m_rom_addr), 64'd0);

        // ---- auto-boot: done at cycle 14 after release
        clear_writes();
        reset = 1'b0;
        step();
        check("ab_busy_c1",   64'(busy),       64'd1);
        check("ab_rom_en_c1", 64'(m_rom_en),   64'd1);
        check("ab_rom_ad_c1", 64'(m_rom_addr), 64'd0);
        repeat (12) step();
        check("ab_done_c13", 64'(done), 64'd0);
        check("ab_busy_c13", 64'(busy), 64'd1);
        step();
        check("ab_done_c14", 64'(done), 64'd1);
        check("ab_busy_c14", 64'(busy), 64'd0);
        check_writes("ab");

        // ---- host stall: host read raised mid-boot
        clear_writes();
        pulse_start();
        step();
        check("hs_busy", 64'(busy), 64'd1);
        s_wb_stb_i = 1'b1;
        s_wb_we_i  = 1'b0;
        s_wb_adr_i = 24'h00_0123;
        stall_bad  = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            if (s_wb_ack_o !== 1'b0 || s_wb_dat_o !== '0) stall_bad = 1'b1;
            step();
        end
        check("hs_stalled", 64'(stall_bad), 64'd0);
        check("hs_done",    64'(done),       64'd1);
        check("hs_ack",     64'(s_wb_ack_o), 64'd1);
        check("hs_rdata",   s_wb_dat_o,      SLAVE_RD);
        check("hs_adr",     64'(m_wb_adr_o), 64'h123);
        check_writes("hs");
        s_wb_stb_i = 1'b0;

        // ---- start deferral: host strobe held for 5 cycles
        clear_writes();
        s_wb_stb_i = 1'b1;
        start      = 1'b1;
        step();
        start      = 1'b0;
        busy_seen  = busy;
        repeat (4) begin
            step();
            busy_seen = busy_seen | busy;
        end
        check("sd_no_busy", 64'(busy_seen), 64'd0);
        s_wb_stb_i = 1'b0;
        step();
        check("sd_busy", 64'(busy), 64'd1);
        check("sd_done_clr", 64'(done), 64'd0);
        wait_done("sd_wait_done", 60);

        // ---- timeout with no ack
        clear_writes();
        ack_en = 1'b0;
        pulse_start();
        repeat (3) step();
        check("to_stb",  64'(m_wb_stb_o), 64'd1);
        check("to_adr",  64'(m_wb_adr_o), 64'h1_0000);
        check("to_we",   64'(m_wb_we_o),  64'd1);
        check("to_sel",  64'(m_wb_sel_o), 64'hff);
        check("to_dat",  m_wb_dat_o,      64'h1111_0000);
        repeat (15) step();
        check("to_err_c16", 64'(error),      64'd0);
        check("to_stb_c16", 64'(m_wb_stb_o), 64'd1);
        step();
        check("to_err",     64'(error),      64'd1);
        check("to_stb_off", 64'(m_wb_stb_o), 64'd0);
        check("to_busy",    64'(busy),       64'd0);
        check("to_done",    64'(done),       64'd0);
        s_wb_stb_i = 1'b1;
        s_wb_we_i  = 1'b1;
        s_wb_adr_i = 24'h00_0055;
        #1;
        check("to_pt_stb", 64'(m_wb_stb_o), 64'd1);
        check("to_pt_adr", 64'(m_wb_adr_o), 64'h55);
        check("to_pt_we",  64'(m_wb_we_o),  64'd1);
        check("to_nwr",    64'(wr_adr.size()), 64'd0);
        s_wb_stb_i = 1'b0;
        s_wb_we_i  = 1'b0;
        ack_en     = 1'b1;

        // ---- mid-boot reset at word 2
        pulse_start();
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            step();
            if (m_wb_stb_o && m_wb_adr_o == 24'h01_0002) found = 1'b1;
        end
        check("mr_word2", 64'(found), 64'd1);
        reset = 1'b1;
        step();
        check("mr_stb",  64'(m_wb_stb_o), 64'd0);
        check("mr_busy", 64'(busy),       64'd0);
        clear_writes();
        reset = 1'b0;
        step();
        check("mr_rom_en", 64'(m_rom_en),   64'd1);
        check("mr_rom_ad", 64'(m_rom_addr), 64'd0);
        wait_done("mr_wait_done", 60);
        check_writes("mr");

        // ---- clock enable toggling: half-rate boot
        clear_writes();
        pulse_start();
        for (int s = 2; s <= 29; s++) begin
            cke = (s % 2 == 1);
            step();
            if (s == 28) check("ck_done_s28", 64'(done), 64'd0);
            if (s == 29) check("ck_done_s29", 64'(done), 64'd1);
        end
        cke = 1'b1;
        check_writes("ck");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
